// File: rtl/tt_sweep_capture_if.sv
// Bundle between tt_sweep_capture (slave) and its requester/function-under-test side (master).
// The ones count is carried only when TT_SWEEP_ONES_COUNT_EN is defined.
interface tt_sweep_capture_if;
    logic         start;
    logic         x0;
    logic         x1;
    logic         x2;
    logic         x3;
    logic         x4;
    logic         x5;
    logic         x6;
    logic         f_in;
    logic         busy;
    logic [127:0] tt;
    logic         tt_valid;
    logic         tt_ready;
`ifdef TT_SWEEP_ONES_COUNT_EN
    logic [7:0]   ones;

    modport slave (
        input  start, f_in, tt_ready,
        output x0, x1, x2, x3, x4, x5, x6, busy, tt, tt_valid, ones
    );
    modport master (
        output start, f_in, tt_ready,
        input  x0, x1, x2, x3, x4, x5, x6, busy, tt, tt_valid, ones
    );
`else
    modport slave (
        input  start, f_in, tt_ready,
        output x0, x1, x2, x3, x4, x5, x6, busy, tt, tt_valid
    );
    modport master (
        output start, f_in, tt_ready,
        input  x0, x1, x2, x3, x4, x5, x6, busy, tt, tt_valid
    );
`endif
endinterface

// File: rtl/tt_sweep_capture.sv
// Sweeps all 128 input vectors of a 7-input function and assembles its truth table.
// Optional minterm counter on the ones port: define TT_SWEEP_ONES_COUNT_EN.
module tt_sweep_capture #(
    parameter int unsigned LATENCY = 0  // pipeline depth of the function under test, 0..7
) (
    input  logic               clk,
    input  logic               rst,
    tt_sweep_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        HOLD
    } state_t;

    state_t       state;
    logic [6:0]   drv;
    logic [6:0]   smp;
    logic [2:0]   lag;
    logic [127:0] tt_q;
    logic         busy_q;
    logic         valid_q;
    logic         cap;
`ifdef TT_SWEEP_ONES_COUNT_EN
    logic [7:0]   ones_q;
`endif

    // Sampling starts once lag has counted off the function's pipeline depth.
    assign cap = busy_q && (lag == 3'(LATENCY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            drv     <= '0;
            smp     <= '0;
            lag     <= '0;
            tt_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef TT_SWEEP_ONES_COUNT_EN
            ones_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SWEEP;
                        drv    <= '0;
                        smp    <= '0;
                        lag    <= '0;
                        tt_q   <= '0;
                        busy_q <= 1'b1;
`ifdef TT_SWEEP_ONES_COUNT_EN
                        ones_q <= '0;
`endif
                    end
                end
                SWEEP, DRAIN: begin
                    // drv wraps to 0 after 127, which is exactly the idle/drain vector
                    if (state == SWEEP) drv <= drv + 7'd1;
                    if (lag != 3'(LATENCY)) lag <= lag + 3'd1;
                    if (cap) begin
                        tt_q[smp] <= bus.f_in;
                        smp       <= smp + 7'd1;
`ifdef TT_SWEEP_ONES_COUNT_EN
                        ones_q    <= ones_q + 8'(bus.f_in);
`endif
                    end
                    if (cap && (smp == 7'd127)) begin
                        state   <= HOLD;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else if ((state == SWEEP) && (drv == 7'd127)) begin
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (bus.tt_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x0       = drv[0];
    assign bus.x1       = drv[1];
    assign bus.x2       = drv[2];
    assign bus.x3       = drv[3];
    assign bus.x4       = drv[4];
    assign bus.x5       = drv[5];
    assign bus.x6       = drv[6];
    assign bus.busy     = busy_q;
    assign bus.tt       = tt_q;
    assign bus.tt_valid = valid_q;
`ifdef TT_SWEEP_ONES_COUNT_EN
    assign bus.ones     = ones_q;
`endif

endmodule
